design_16_arb: RTL

Round-robin arbiter and sequencer that time-shares one design_16 datapath instance among N requesters. It accepts operand pairs from requesters and issues a one-cycle start to the shared unit. It holds the operands stable until the unit's valid arrives, then routes y back to the owning requester. It sits between the requester fabric and a single design_16, on the same clock and reset.

---
 rtl/design_16_arb.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/design_16_arb.sv
// Round-robin arbiter/sequencer sharing one design_16 datapath among N requesters.
// Optional WAIT watchdog enabled by defining DESIGN16_ARB_TIMEOUT_EN.
module design_16_arb #(
  parameter int W   = 10,
  parameter int N   = 4,
  parameter int TMO = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_in,
  input  logic [N*W-1:0] b_in,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   rsp_y,
  output logic           rsp_err,
  output logic           busy,
  output logic           u_start,
  output logic [W-1:0]   u_a,
  output logic [W-1:0]   u_b,
  input  logic [W-1:0]   u_y,
  input  logic           u_valid
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // Handshake: req is a level held until the one-cycle gnt; operands are taken
  // only in the gnt cycle; the result is returned by a one-cycle rsp_valid.
  logic [1:0]    state;
  logic [LW-1:0] last;
  logic [LW-1:0] owner;
  logic [LW-1:0] win;
  logic [LW-1:0] idx;
  logic          found;

  // Search starts just after the last winner so the previous owner comes last.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = LW'((int'(last) + i) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (rst_n && state == IDLE && found) gnt[win] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (state == RESP) rsp_valid[owner] = 1'b1;
  end

  assign u_start = (state == ISSUE);
  assign busy    = (state != IDLE);

`ifdef DESIGN16_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TMO + 1);
  logic [CW-1:0] cnt;
  logic          err_q;

  assign rsp_err = (state == RESP) && err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= LW'(N - 1);
      owner <= '0;
      u_a   <= '0;
      u_b   <= '0;
      rsp_y <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          u_a   <= a_in[win*W +: W];
          u_b   <= b_in[win*W +: W];
          owner <= win;
          last  <= win;
          state <= ISSUE;
        end
        ISSUE: begin
          cnt   <= '0;
          err_q <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          // A valid on the final watchdog cycle still counts as completion.
          if (u_valid) begin
            rsp_y <= u_y;
            state <= RESP;
          end else if (cnt == CW'(TMO - 1)) begin
            rsp_y <= '0;
            err_q <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign rsp_err = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= LW'(N - 1);
      owner <= '0;
      u_a   <= '0;
      u_b   <= '0;
      rsp_y <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          u_a   <= a_in[win*W +: W];
          u_b   <= b_in[win*W +: W];
          owner <= win;
          last  <= win;
          state <= ISSUE;
        end
        ISSUE: state <= WAIT;
        WAIT: if (u_valid) begin
          rsp_y <= u_y;
          state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule
